// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: funct3 codes, sequencer states and requester ids shared by dmem_arbiter and its picker.
package dmem_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    // Halfwords need addr[0]==0, words need addr[1:0]==0; byte and invalid sizes never fault.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core and DMA request/response channels plus the single-port memory bus.
interface dmem_arbiter_if;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [2:0]  c_funct3;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_funct3;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [2:0]  mem_funct3;
    logic        mem_read_enable, mem_write_enable;
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_addr, d_wdata, d_funct3,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_write_data, mem_funct3, mem_read_enable, mem_write_enable,
        input  mem_read_data
    );
    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_addr, d_wdata, d_funct3,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_write_data, mem_funct3, mem_read_enable, mem_write_enable,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way combinational picker; round-robin on last_grant, or core-first when prio_fixed.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_prio_fixed,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt[REQ_CORE] = i_req[REQ_CORE] & (~i_req[REQ_DMA] | i_prio_fixed | i_last_grant == REQ_DMA);
        o_gnt[REQ_DMA]  = i_req[REQ_DMA] & ~o_gnt[REQ_CORE];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates core/DMA onto the data memory, one IDLE->ACCESS->RESP transaction at a time.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of issuing them.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit CORE_PRIO = 1'b0,
    parameter int MEM_WORDS = 1024
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS) + 2;
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << AW) - 64'd1);
    state_t      r_state, w_next;
    logic        r_id, r_last, r_we;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_f3;
    logic [1:0]  w_pick, w_take;
    logic        w_err, w_access, w_resp;
    logic [31:0] w_addr_in;
    logic [2:0]  w_f3_in;

    rr_arb2 u_arb (
        .i_req       ({bus.d_req, bus.c_req}),
        .i_last_grant(r_last),
        .i_prio_fixed(CORE_PRIO),
        .o_gnt       (w_pick)
    );

    assign w_take    = (r_state == IDLE) ? w_pick : 2'b00;
    assign w_addr_in = w_take[REQ_DMA] ? bus.d_addr : bus.c_addr;
    assign w_f3_in   = w_take[REQ_DMA] ? bus.d_funct3 : bus.c_funct3;

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_err <= 1'b0;
        else if (|w_take)
            r_err <= misaligned(w_f3_in, w_addr_in[1:0]);
    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_access             = r_state == ACCESS;
        w_resp               = r_state == RESP;
        w_next               = w_access ? RESP : (|w_take) ? ACCESS : IDLE;
        bus.mem_address      = w_access ? (r_addr & ADDR_MASK) : '0;
        bus.mem_write_data   = w_access ? r_wdata : '0;
        bus.mem_funct3       = w_access ? r_f3 : '0;
        bus.mem_read_enable  = w_access & ~w_err & ~r_we;
        bus.mem_write_enable = w_access & ~w_err & r_we;
        bus.c_gnt            = w_take[REQ_CORE];
        bus.d_gnt            = w_take[REQ_DMA];
        bus.c_rvalid         = w_resp & (r_id == REQ_CORE);
        bus.d_rvalid         = w_resp & (r_id == REQ_DMA);
        bus.c_rdata          = (w_resp & (r_id == REQ_CORE)) ? r_rdata : '0;
        bus.d_rdata          = (w_resp & (r_id == REQ_DMA)) ? r_rdata : '0;
        bus.c_err            = w_resp & (r_id == REQ_CORE) & w_err;
        bus.d_err            = w_resp & (r_id == REQ_DMA) & w_err;
    end

    // Stores and faulted accesses return zero data; the read bus is only sampled while read_enable is high.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_id    <= REQ_CORE;
            r_last  <= REQ_DMA;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_rdata <= '0;
        end else if (|w_take) begin
            r_id    <= w_take[REQ_DMA];
            r_last  <= w_take[REQ_DMA];
            r_we    <= w_take[REQ_DMA] ? bus.d_we : bus.c_we;
            r_addr  <= w_addr_in;
            r_wdata <= w_take[REQ_DMA] ? bus.d_wdata : bus.c_wdata;
            r_f3    <= w_f3_in;
        end else if (w_access)
            r_rdata <= (r_we | w_err) ? '0 : bus.mem_read_data;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and random traffic checked against
// a byte-array reference memory and a transaction-level grant model.
module tb_dmem_arbiter;
    import dmem_pkg::*;
    localparam bit CP = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    typedef struct {
        int          r;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] er;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          passed = 0;
    int          wr_count = 0;
    logic        exp_last = 1'b1;
    logic [7:0]  mem [4096];
    logic [7:0]  exp_mem [4096];
    logic [11:0] ea;

    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus1();
    dmem_arbiter #(.CORE_PRIO(CP), .MEM_WORDS(1024)) dut (.clk(clk), .reset(reset), .bus(bus));
    dmem_arbiter #(.CORE_PRIO(1'b1), .MEM_WORDS(1024)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            F3_LB:   return {{24{raw[7]}}, raw[7:0]};
            F3_LH:   return {{16{raw[15]}}, raw[15:0]};
            F3_LW:   return raw;
            F3_LBU:  return {24'h0, raw[7:0]};
            F3_LHU:  return {16'h0, raw[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Memory environment: combinational read (garbage when disabled), byte-lane write on the edge.
    assign ea = bus.mem_address[11:0];
    assign bus.mem_read_data = bus.mem_read_enable ?
        fmt({mem[ea + 12'd3], mem[ea + 12'd2], mem[ea + 12'd1], mem[ea]}, bus.mem_funct3) : 32'hDEAD_DEAD;
    assign bus1.mem_read_data = 32'h0;

    always @(posedge clk)
        if (bus.mem_write_enable) begin
            wr_count <= wr_count + 1;
            mem[ea] <= bus.mem_write_data[7:0];
            if (bus.mem_funct3[1:0] != 2'b00) mem[ea + 12'd1] <= bus.mem_write_data[15:8];
            if (bus.mem_funct3[1:0] == 2'b10) begin
                mem[ea + 12'd2] <= bus.mem_write_data[23:16];
                mem[ea + 12'd3] <= bus.mem_write_data[31:24];
            end
        end

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [11:0] e;
        e = a[11:0];
        return fmt({exp_mem[e + 12'd3], exp_mem[e + 12'd2], exp_mem[e + 12'd1], exp_mem[e]}, f3);
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 0;
        for (int i = 0; i < n; i++) exp_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input int r, input logic q, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        if (r == 0) begin
            bus.c_req = q; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd; bus.c_funct3 = f3;
        end else begin
            bus.d_req = q; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_funct3 = f3;
        end
    endtask

    // One isolated transaction: gnt at negedge N, ACCESS at N+1, response at N+2.
    task automatic xact(input int r, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] er, input logic ee, input string nm);
        logic g;
        g = 1'b0;
        drive(r, 1'b1, we, a, wd, f3);
        for (int n = 0; n < 8 && !g; n++) begin
            @(negedge clk);
            g = (r == 0) ? bus.c_gnt : bus.d_gnt;
        end
        chk({nm, " gnt"}, {bus.d_gnt, bus.c_gnt}, (r == 0) ? 2'b01 : 2'b10);
        @(posedge clk);
        #1 drive(r, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        chk({nm, " acc rvalid"}, {bus.d_rvalid, bus.c_rvalid}, 2'b00);
        chk({nm, " acc en"}, {bus.mem_read_enable, bus.mem_write_enable}, ee ? 2'b00 : we ? 2'b01 : 2'b10);
        if (!ee) begin
            chk({nm, " acc addr"}, bus.mem_address, a & 32'hFFF);
            chk({nm, " acc f3"}, bus.mem_funct3, f3);
            if (we) chk({nm, " acc wdata"}, bus.mem_write_data, wd);
        end
        @(negedge clk);
        chk({nm, " rvalid"}, {bus.d_rvalid, bus.c_rvalid}, (r == 0) ? 2'b01 : 2'b10);
        chk({nm, " rdata"}, (r == 0) ? bus.c_rdata : bus.d_rdata, er);
        chk({nm, " err"}, (r == 0) ? bus.c_err : bus.d_err, ee);
        chk({nm, " resp en"}, {bus.mem_read_enable, bus.mem_write_enable}, 2'b00);
        if (we && !ee) model_store(a, f3, wd);
        exp_last = (r != 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        tbl [12];
        logic [1:0]  ex;
        logic        g, w, bad, we;
        logic [1:0]  sz;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          wn, wc, r;
        tbl = '{
            '{0, 1'b1, 32'h10, 32'hDEADBEEF, F3_SW,  32'h0},
            '{0, 1'b0, 32'h10, 32'h0,        F3_LW,  32'hDEADBEEF},
            '{1, 1'b1, 32'h13, 32'hFFFFFF80, F3_SB,  32'h0},
            '{0, 1'b0, 32'h13, 32'h0,        F3_LB,  32'hFFFFFF80},
            '{0, 1'b0, 32'h13, 32'h0,        F3_LBU, 32'h00000080},
            '{0, 1'b0, 32'h10, 32'h0,        F3_LW,  32'h80ADBEEF},
            '{1, 1'b1, 32'h24, 32'h5555ABCD, F3_SH,  32'h0},
            '{1, 1'b0, 32'h24, 32'h0,        F3_LH,  32'hFFFFABCD},
            '{1, 1'b0, 32'h24, 32'h0,        F3_LHU, 32'h0000ABCD},
            '{0, 1'b1, 32'h20, 32'hCAFEF00D, F3_SW,  32'h0},
            '{1, 1'b0, 32'h20, 32'h0,        F3_LW,  32'hCAFEF00D},
            '{0, 1'b0, 32'h10, 32'h0,        3'b011, 32'h0}
        };
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        {bus1.c_req, bus1.c_we, bus1.c_addr, bus1.c_wdata, bus1.c_funct3} = '0;
        {bus1.d_req, bus1.d_we, bus1.d_addr, bus1.d_wdata, bus1.d_funct3} = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("rst gnt", {bus.c_gnt, bus.d_gnt, bus1.c_gnt, bus1.d_gnt}, 0);
        chk("rst rvalid", {bus.c_rvalid, bus.d_rvalid, bus1.c_rvalid, bus1.d_rvalid}, 0);
        chk("rst err", {bus.c_err, bus.d_err}, 0);
        chk("rst rdata", {bus.c_rdata, bus.d_rdata}, 0);
        chk("rst mem addr/wdata", {bus.mem_address, bus.mem_write_data}, 0);
        chk("rst mem ctl", {bus.mem_funct3, bus.mem_read_enable, bus.mem_write_enable}, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_read_enable,
                         bus.mem_write_enable, |bus.mem_address, |bus.mem_write_data, |bus.mem_funct3}, 0);
        end
        @(posedge clk);
        #1;
        foreach (tbl[i]) xact(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].f3, tbl[i].er, 1'b0, "vec");
        // Contention with both requests held: grant every third cycle, alternating unless core-priority.
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, F3_LW);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, F3_LW);
        {bus1.c_req, bus1.d_req} = 2'b11;
        wn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wn == 0) begin
                w = CP ? 1'b0 : ~exp_last;
                ex = w ? 2'b10 : 2'b01;
                exp_last = w;
                wn = 2;
            end else begin
                ex = 2'b00;
                wn--;
            end
            chk("rr gnt", {bus.d_gnt, bus.c_gnt}, ex);
            chk("prio gnt", {bus1.d_gnt, bus1.c_gnt}, (i % 3 == 0) ? 2'b01 : 2'b00);
        end
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        bus1.c_req = 1'b0;
        @(negedge clk);
        chk("prio dma after core drops", {bus1.d_gnt, bus1.c_gnt}, 2'b10);
        @(posedge clk);
        #1 bus1.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset while a store sits in ACCESS: enables drop at once, no commit, no response.
        drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, F3_SW);
        g = 1'b0;
        for (int n = 0; n < 8 && !g; n++) begin
            @(negedge clk);
            g = bus.c_gnt;
        end
        chk("rst-mid gnt", g, 1);
        @(posedge clk);
        #1 bus.c_req = 1'b0;
        chk("rst-mid we before", bus.mem_write_enable, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst-mid outs", {bus.mem_write_enable, bus.mem_read_enable, |bus.mem_address, |bus.mem_write_data,
                             bus.c_rvalid, bus.d_rvalid, bus.c_gnt, bus.d_gnt}, 0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad |= bus.c_rvalid | bus.d_rvalid;
        end
        reset = 1'b0;
        exp_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bad |= bus.c_rvalid | bus.d_rvalid;
        end
        chk("rst-mid no rvalid", bad, 0);
        @(posedge clk);
        #1 xact(0, 1'b0, 32'h20, 32'h0, F3_LW, 32'hCAFEF00D, 1'b0, "rst-mid lw");
        wc = wr_count;
        xact(0, 1'b1, 32'h21, 32'h0000BEEF, F3_SH, 32'h0, MIS, "sh21");
        chk("sh21 writes", wr_count - wc, MIS ? 0 : 1);
        xact(1, 1'b0, 32'h20, 32'h0, F3_LW, model_load(32'h20, F3_LW), 1'b0, "lw20 after sh21");
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(1, 0));
            sz = 2'($urandom_range(2, 0));
            we = 1'($urandom);
            f3 = we ? {1'b0, sz} : {1'($urandom) & (sz != 2'b10), sz};
            a = $urandom & 32'hFFF0_00FF;
            a = a & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            xact(r, we, a, wd, f3, we ? 32'h0 : model_load(a, f3), 1'b0, "rand");
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the DMA/debug port.
- Arbitrates fairly, latches the winning request, drives the memory port for exactly one access cycle, captures the load result, then returns a one-cycle response pulse to the winner.
- At most one transaction is in flight.

Parameters:
- CORE_PRIO, 0, when 1 the core always wins contention (fixed priority); when 0 round-robin.
- MEM_WORDS, 1024, memory depth in words; the effective address is addr[$clog2(MEM_WORDS)+1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  core request; held with its fields until c_gnt.
- c_we  in  1  1 = store, 0 = load.
- c_addr  in  32  byte address.
- c_wdata  in  32  store data.
- c_funct3  in  3  load/store type (LB/LH/LW/LBU/LHU, SB/SH/SW).
- c_gnt  out  1  combinational accept; fields are latched at this edge.
- c_rvalid  out  1  one-cycle response pulse.
- c_rdata  out  32  load data, valid with c_rvalid; 0 for stores.
- c_err  out  1  access fault, valid with c_rvalid.
- d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata, d_err: same as the c_ set, for requester 1.
- mem_address  out  32  to the memory.
- mem_write_data  out  32  to the memory.
- mem_funct3  out  3  to the memory.
- mem_read_enable  out  1  to the memory.
- mem_write_enable  out  1  to the memory.
- mem_read_data  in  32  from the memory; combinational read, high-Z when read_enable=0.

Behaviour:
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is set, the picker selects a winner and asserts that requester's gnt in the same cycle.
  - At the clock edge: latch we/addr/wdata/funct3 and the winner id, update last_grant, go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - Drive mem_* from the latched registers.
  - mem_write_enable = latched we; mem_read_enable = ~latched we.
  - At the edge, the memory commits the store. For a load, mem_read_data is captured into the rdata register.
  - Go to RESP.
- RESP:
  - Winner's rvalid=1 for exactly one cycle, with rdata and err.
  - Return to IDLE.
- gnt is never asserted outside IDLE; requests arriving in ACCESS/RESP wait.
- Latency:
  - Load: gnt in cycle N, response in cycle N+2.
  - Sustained throughput: one access per 3 cycles.
- Arbitration:
  - Single requester always wins.
  - Contention with CORE_PRIO=0: grant the requester not in last_grant.
  - Contention with CORE_PRIO=1: core wins.
  - last_grant resets to 1 (DMA), so the core wins the first contention.
- Outside ACCESS, mem_address, mem_write_data, mem_funct3, mem_read_enable and mem_write_enable are all 0. The memory therefore never sees a spurious write, and a Z read is never captured.
- Reset values:
  - State IDLE; all gnt, rvalid and err outputs 0.
  - All rdata 0; all mem_* outputs 0; last_grant 1.
- Reset mid-operation:
  - Asynchronous return to IDLE.
  - A store still in ACCESS when reset asserts is not committed by the arbiter; enables drop immediately.
  - A pending response is discarded and no rvalid is issued.
- funct3 is passed through unchecked, except under the optional feature. The memory ignores or zeroes invalid codes, and the arbiter still completes the transaction with err=0.
- A requester holding req through its own RESP is treated as a new request in the following IDLE cycle.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: the address is checked at the grant edge. Halfword with addr[0]=1, or word with addr[1:0]!=0, is flagged misaligned.
  - The access goes IDLE -> ACCESS with both mem enables held 0, then RESP.
  - The response has err=1 and rdata=0.
  - Memory contents are unchanged.
- Undefined: err outputs are tied 0, no alignment logic is built, and the raw address is passed through.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - State enum {IDLE, ACCESS, RESP}.
  - Requester ids REQ_CORE=0, REQ_DMA=1.
- Sub-module rr_arb2: 2-way combinational picker.
  - Inputs: req[1:0], last_grant, prio_fixed.
  - Output: one-hot gnt.

Test Plan:
- Core SW 0xDEADBEEF @0x10, then LW @0x10: c_gnt cycle N, c_rvalid cycle N+2 with rdata 0xDEADBEEF, err=0; d_* stay idle.
- DMA SB 0x80 @0x13, then core LB @0x13 -> 0xFFFFFF80; core LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- Both req held continuously with CORE_PRIO=0: grants alternate core, DMA, core, DMA, one every 3 cycles. With CORE_PRIO=1: core only while c_req stays high.
- Reset asserted during ACCESS of core SW 0x12345678 @0x20: no rvalid, all outputs 0 at once; a later LW @0x20 returns the prior value.
- DMEM_ALIGN_CHECK_EN defined, core SH @0x21: c_rvalid with c_err=1, rdata=0, mem_write_enable never 1. Without the macro: c_err=0 and the store proceeds.
- Idle bench with no req for 20 cycles: all mem_* stay 0 and no gnt or rvalid pulses.
